// File: rtl/hex_pkg.sv
// Shared definitions for the ASCII hex receive path: FSM state encoding
// and the ASCII character ranges that count as hex digits.
package hex_pkg;

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UF = 8'h46;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LF = 8'h66;

  function automatic logic in_range(input logic [7:0] code,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (code >= lo) && (code <= hi);
  endfunction

endpackage

// File: rtl/hex_byte_assembler_if.sv
// Character stream from the UART receiver and the assembled-byte results.
// master drives characters and observes results; slave is the assembler.
interface hex_byte_assembler_if;

  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_ERROR;
  logic [7:0] Data_out;
  logic       Data_valid;
  logic       Hex_error;
  logic       Digit_pending;

  modport master (
    output Rx_DATA, Rx_VALID, Rx_ERROR,
    input  Data_out, Data_valid, Hex_error, Digit_pending
  );

  modport slave (
    input  Rx_DATA, Rx_VALID, Rx_ERROR,
    output Data_out, Data_valid, Hex_error, Digit_pending
  );

endinterface

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F' and, when
// HEX_LOWERCASE_EN is defined, 'a'-'f'.
module ascii_hex_decode
  import hex_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [3:0] nibble,
  output logic       is_hex
);

  // Letters sit at offset 1 within their column, so low nibble + 9 gives 10..15
  always_comb begin
    nibble = 4'h0;
    is_hex = 1'b0;
    if (in_range(ascii, ASCII_0, ASCII_9)) begin
      nibble = ascii[3:0];
      is_hex = 1'b1;
    end else if (in_range(ascii, ASCII_UA, ASCII_UF)) begin
      nibble = ascii[3:0] + 4'd9;
      is_hex = 1'b1;
    end
`ifdef HEX_LOWERCASE_EN
    else if (in_range(ascii, ASCII_LA, ASCII_LF)) begin
      nibble = ascii[3:0] + 4'd9;
      is_hex = 1'b1;
    end
`else
    else begin
      nibble = 4'h0;
      is_hex = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/hex_byte_assembler.sv
// Rebuilds a byte from two ASCII hex characters with an inter-digit timeout.
// Optional lowercase digit support via HEX_LOWERCASE_EN (see ascii_hex_decode).
module hex_byte_assembler
  import hex_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                clock,
  input  logic                reset,
  hex_byte_assembler_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [3:0]       nib_q, nib_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [3:0]       dec_nibble;
  logic             dec_is_hex;
  logic             char_ok;

  ascii_hex_decode u_decode (
    .ascii  (bus.Rx_DATA),
    .nibble (dec_nibble),
    .is_hex (dec_is_hex)
  );

  assign char_ok = dec_is_hex & ~bus.Rx_ERROR;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_HI;
      nib_q   <= 4'h0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // A character arriving on the expiry cycle takes priority over the timeout
  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      WAIT_HI: begin
        if (bus.Rx_VALID) begin
          if (char_ok) begin
            nib_d   = dec_nibble;
            cnt_d   = '0;
            state_d = WAIT_LO;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_LO: begin
        if (bus.Rx_VALID) begin
          if (char_ok) begin
            data_d  = {nib_q, dec_nibble};
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          nib_d   = 4'h0;
          state_d = WAIT_HI;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          nib_d   = 4'h0;
          state_d = WAIT_HI;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = WAIT_HI;
      end
    endcase
  end

  assign bus.Data_out      = data_q;
  assign bus.Data_valid    = valid_q;
  assign bus.Hex_error     = err_q;
  assign bus.Digit_pending = (state_q == WAIT_LO);

endmodule

// File: tb/tb_hex_byte_assembler.sv
// Scoreboard bench for hex_byte_assembler; lowercase expectations follow
// HEX_LOWERCASE_EN so the bench matches whichever build it is compiled with.
module tb_hex_byte_assembler;

  localparam int T = 8;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic clock;
  logic reset;
  int   cycle_count;
  int   n_compared;
  int   n_mismatched;
  ev_t  sb[$];

  bit         m_pending;
  logic [3:0] m_hi;
  int         m_hi_cyc;
  logic [7:0] m_data;

  hex_byte_assembler_if bus ();

  hex_byte_assembler #(.CNT_W(16), .TIMEOUT_CYCLES(T)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cycle_count <= cycle_count + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at cycle %0d",
               tag, observed, expected, cycle_count);
    end
  endtask

  function automatic bit modelDecode(input logic [7:0] c, output logic [3:0] n);
    logic [7:0] t;
    n = 4'h0;
    if (c >= "0" && c <= "9") begin
      t = c - 8'h30;
      n = t[3:0];
      return 1'b1;
    end
    if (c >= "A" && c <= "F") begin
      t = c - 8'h41 + 8'd10;
      n = t[3:0];
      return 1'b1;
    end
`ifdef HEX_LOWERCASE_EN
    if (c >= "a" && c <= "f") begin
      t = c - 8'h61 + 8'd10;
      n = t[3:0];
      return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  function automatic void pushEvent(input bit is_err, input logic [7:0] data,
                                    input int cyc);
    ev_t e;
    e.is_err = is_err;
    e.data   = data;
    e.cyc    = cyc;
    sb.push_back(e);
  endfunction

  // Drive one character for one cycle and predict what the DUT must do with it
  task automatic applyStimulus(input logic [7:0] d, input bit err);
    logic [3:0] n;
    bit         ok;
    int         x;
    @(negedge clock);
    bus.Rx_DATA  = d;
    bus.Rx_VALID = 1'b1;
    bus.Rx_ERROR = err;
    x  = cycle_count + 1;
    ok = modelDecode(d, n) && !err;
    if (!m_pending) begin
      if (ok) begin
        m_pending = 1'b1;
        m_hi      = n;
        m_hi_cyc  = x;
      end else begin
        pushEvent(1'b1, m_data, x);
      end
    end else begin
      m_pending = 1'b0;
      if (ok) begin
        m_data = {m_hi, n};
        pushEvent(1'b0, m_data, x);
      end else begin
        pushEvent(1'b1, m_data, x);
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.Rx_VALID = 1'b0;
      bus.Rx_ERROR = 1'b0;
      if (m_pending && (cycle_count + 1 == m_hi_cyc + T)) begin
        pushEvent(1'b1, m_data, cycle_count + 1);
        m_pending = 1'b0;
      end
    end
  endtask

  task automatic pulseReset();
    @(negedge clock);
    bus.Rx_VALID = 1'b0;
    bus.Rx_ERROR = 1'b0;
    reset = 1'b0;
    m_pending = 1'b0;
    m_data = 8'h00;
    #1;
    checkOutput("rst_data_out", bus.Data_out, 8'h00);
    checkOutput("rst_pending", bus.Digit_pending, 1'b0);
    checkOutput("rst_valid", bus.Data_valid, 1'b0);
    checkOutput("rst_error", bus.Hex_error, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Retire expectations whose cycle has passed, then match any output pulse
  always @(negedge clock) begin
    if (reset) begin
      while (sb.size() > 0 && sb[0].cyc < cycle_count) begin
        checkOutput("missed_event", cycle_count, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (bus.Data_valid || bus.Hex_error) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_event", {30'b0, bus.Data_valid, bus.Hex_error}, 32'd0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          checkOutput("event_cycle", cycle_count, e.cyc);
          checkOutput("event_kind", {30'b0, bus.Data_valid, bus.Hex_error},
                      e.is_err ? 32'd1 : 32'd2);
          checkOutput("event_data_out", bus.Data_out, e.data);
        end
      end
    end
  end

  initial begin
    logic [7:0] pool [12];
    cycle_count  = 0;
    n_compared   = 0;
    n_mismatched = 0;
    m_pending    = 1'b0;
    m_hi         = 4'h0;
    m_hi_cyc     = 0;
    m_data       = 8'h00;
    reset        = 1'b0;
    bus.Rx_DATA  = 8'h00;
    bus.Rx_VALID = 1'b0;
    bus.Rx_ERROR = 1'b0;
    pool = '{8'h30, 8'h39, 8'h41, 8'h46, 8'h47, 8'h61,
             8'h66, 8'h2F, 8'h3A, 8'h40, 8'h67, 8'h20};

    #2;
    checkOutput("init_data_out", bus.Data_out, 8'h00);
    checkOutput("init_valid", bus.Data_valid, 1'b0);
    checkOutput("init_error", bus.Hex_error, 1'b0);
    checkOutput("init_pending", bus.Digit_pending, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    idleCycles(2);

    $display("[TB] '4','1' with a gap");
    applyStimulus(8'h34, 1'b0);
    idleCycles(1);
    checkOutput("pending_between", bus.Digit_pending, 1'b1);
    idleCycles(2);
    applyStimulus(8'h31, 1'b0);
    idleCycles(2);
    checkOutput("byte_41", bus.Data_out, 8'h41);
    checkOutput("pending_after", bus.Digit_pending, 1'b0);

    $display("[TB] back-to-back pairs");
    applyStimulus(8'h46, 1'b0);
    applyStimulus(8'h46, 1'b0);
    applyStimulus(8'h30, 1'b0);
    applyStimulus(8'h39, 1'b0);
    idleCycles(2);
    checkOutput("byte_09", bus.Data_out, 8'h09);

    $display("[TB] non-hex low digit");
    applyStimulus(8'h37, 1'b0);
    applyStimulus(8'h47, 1'b0);
    idleCycles(2);
    checkOutput("g_data_held", bus.Data_out, 8'h09);
    checkOutput("g_pending", bus.Digit_pending, 1'b0);
    applyStimulus(8'h41, 1'b0);
    applyStimulus(8'h42, 1'b0);
    idleCycles(2);
    checkOutput("byte_ab", bus.Data_out, 8'hAB);

    $display("[TB] lowercase pair");
    applyStimulus(8'h61, 1'b0);
    applyStimulus(8'h62, 1'b0);
    idleCycles(2);
    checkOutput("lower_data", bus.Data_out, m_data);

    $display("[TB] timeout and exact-expiry digit");
    applyStimulus(8'h35, 1'b0);
    idleCycles(T + 2);
    checkOutput("timeout_pending", bus.Digit_pending, 1'b0);
    applyStimulus(8'h36, 1'b0);
    idleCycles(T - 1);
    applyStimulus(8'h37, 1'b0);
    idleCycles(2);
    checkOutput("expiry_byte", bus.Data_out, 8'h67);
    applyStimulus(8'h38, 1'b0);
    idleCycles(T);
    applyStimulus(8'h39, 1'b0);
    idleCycles(1);
    checkOutput("late_digit_is_high", bus.Digit_pending, 1'b1);
    applyStimulus(8'h43, 1'b0);
    idleCycles(2);
    checkOutput("late_byte", bus.Data_out, 8'h9C);

    $display("[TB] reset mid-sequence");
    applyStimulus(8'h33, 1'b0);
    idleCycles(1);
    pulseReset();
    applyStimulus(8'h34, 1'b0);
    idleCycles(2);
    checkOutput("post_reset_pending", bus.Digit_pending, 1'b1);
    checkOutput("post_reset_data", bus.Data_out, 8'h00);
    applyStimulus(8'h35, 1'b0);
    idleCycles(2);
    checkOutput("post_reset_byte", bus.Data_out, 8'h45);

    $display("[TB] receiver error in WAIT_LO, error without valid");
    applyStimulus(8'h38, 1'b0);
    applyStimulus(8'h35, 1'b1);
    idleCycles(1);
    checkOutput("rxerr_pending", bus.Digit_pending, 1'b0);
    @(negedge clock);
    bus.Rx_ERROR = 1'b1;
    idleCycles(1);
    applyStimulus(8'h31, 1'b0);
    applyStimulus(8'h32, 1'b0);
    idleCycles(2);
    checkOutput("rxerr_byte", bus.Data_out, 8'h12);

    $display("[TB] random stream");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(pool[$urandom_range(11)], ($urandom_range(7) == 0));
      idleCycles($urandom_range(2));
    end
    idleCycles(T + 3);
    checkOutput("final_data", bus.Data_out, m_data);
    checkOutput("queue_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
